// File: rtl/md5_pkg.sv
// md5_pkg
// Shared constants and types for the MD5 target table.
//   HASH_W          digest width in bits (multiple of 8)
//   BYTES_PER_HASH  bytes streamed per digest
//   BCNT_W          byte counter width
//   DEFAULT_HASH    value returned for invalid / out-of-range entries
//   load_state_t    byte loader FSM states
//   scan_state_t    sweep FSM states
package md5_pkg;

    localparam int HASH_W         = 128;
    localparam int BYTES_PER_HASH = HASH_W / 8;
    localparam int BCNT_W         = (BYTES_PER_HASH > 1) ? $clog2(BYTES_PER_HASH) : 1;

    localparam logic [HASH_W-1:0] DEFAULT_HASH = '0;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } load_state_t;

    typedef enum logic {
        SC_IDLE = 1'b0,
        SC_SCAN = 1'b1
    } scan_state_t;

    // Digests arrive MSB byte first, so each new byte enters at the bottom
    // and everything already received moves up by one byte.
    function automatic logic [HASH_W-1:0] shift_in_byte(input logic [HASH_W-1:0] acc,
                                                        input logic [7:0]        b);
        return (acc << 8) | HASH_W'(b);
    endfunction

endpackage

// File: rtl/md5_target_table_if.sv
// md5_target_table_if
// Host-side load stream and sweep stream of the MD5 target table.
//   master : host / comparator side (drives starts, bytes, scan_ready)
//   slave  : table side (drives ready, pulses, scan beats)
// Signals:
//   load_start, load_idx, in_data, in_valid, in_ready, load_done, load_err
//   scan_start, scan_valid, scan_ready, scan_data, scan_idx, scan_busy, scan_done
interface md5_target_table_if #(
    parameter int IDX_W = 4
) ();
    import md5_pkg::*;

    logic              load_start;
    logic [IDX_W-1:0]  load_idx;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              load_done;
    logic              load_err;

    logic              scan_start;
    logic              scan_valid;
    logic              scan_ready;
    logic [HASH_W-1:0] scan_data;
    logic [IDX_W-1:0]  scan_idx;
    logic              scan_busy;
    logic              scan_done;

    modport master (
        output load_start, load_idx, in_data, in_valid, scan_start, scan_ready,
        input  in_ready, load_done, load_err,
               scan_valid, scan_data, scan_idx, scan_busy, scan_done
    );

    modport slave (
        input  load_start, load_idx, in_data, in_valid, scan_start, scan_ready,
        output in_ready, load_done, load_err,
               scan_valid, scan_data, scan_idx, scan_busy, scan_done
    );

endinterface

// File: rtl/md5_byte_loader.sv
// md5_byte_loader
// Assembles a digest from a byte stream and hands it to the table as a
// single-cycle commit.
// Ports:
//   CLK, reset       clock, synchronous active-high reset
//   load_start_i     begin loading entry load_idx_i
//   load_idx_i       target entry
//   in_data_i        digest byte, MSB byte first
//   in_valid_i       in_data_i valid
//   in_ready_o       loader accepts a byte
//   load_done_o      1-cycle pulse after the commit
//   load_err_o       1-cycle pulse after a rejected load_start_i
//   commit_en_o      write strobe, asserted in the cycle of the final byte
//   commit_idx_o     entry being written
//   commit_data_o    full digest being written
//
// state   | meaning
// --------+----------------------------------------------------------
// LD_IDLE | waiting for load_start; bytes are ignored
// LD_LOAD | accepting bytes into the shift register for entry idx_q
module md5_byte_loader
    import md5_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              load_start_i,
    input  logic [IDX_W-1:0]  load_idx_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic              commit_en_o,
    output logic [IDX_W-1:0]  commit_idx_o,
    output logic [HASH_W-1:0] commit_data_o
);

    localparam logic [IDX_W:0]    DEPTH_C   = (IDX_W+1)'(DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_HASH - 1);

    load_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [BCNT_W-1:0] cnt_q,   cnt_d;
    logic [HASH_W-1:0] shift_q, shift_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;
    logic              commit_en;
    logic [HASH_W-1:0] shifted;

    assign shifted = shift_in_byte(shift_q, in_data_i);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= LD_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        commit_en = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (load_start_i) begin
                    if ({1'b0, load_idx_i} < DEPTH_C) begin
                        state_d = LD_LOAD;
                        idx_d   = load_idx_i;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LD_LOAD: begin
                // A second start cannot preempt a load in flight.
                if (load_start_i) begin
                    err_d = 1'b1;
                end
                if (in_valid_i) begin
                    shift_d = shifted;
                    cnt_d   = cnt_q + BCNT_W'(1);
                    if (cnt_q == LAST_BYTE) begin
                        // The final byte is written straight from the
                        // combinational shift so the table updates on
                        // this same edge.
                        commit_en = 1'b1;
                        done_d    = 1'b1;
                        state_d   = LD_IDLE;
                    end
                end
            end
        endcase
    end

    assign in_ready_o    = (state_q == LD_LOAD);
    assign load_done_o   = done_q;
    assign load_err_o    = err_q;
    assign commit_en_o   = commit_en;
    assign commit_idx_o  = idx_q;
    assign commit_data_o = shifted;

endmodule

// File: rtl/md5_target_table.sv
// md5_target_table
// Runtime-loadable table of DEPTH MD5 target digests with a registered
// random-access read port and a backpressured sweep over valid entries.
// Ports:
//   CLK, reset    clock, synchronous active-high reset
//   selector      random-access read index
//   dataOut       registered digest at selector (DEFAULT_HASH if invalid)
//   table_clear   clears all valid bits on the next edge
//   entry_valid   per-entry valid bitmap
//   bus           load stream and sweep stream (slave side)
//
// state   | meaning
// --------+----------------------------------------------------------
// SC_IDLE | no sweep; scan_start begins one at entry 0
// SC_SCAN | walking ptr over the table, emitting valid entries
module md5_target_table
    import md5_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic [IDX_W-1:0]    selector,
    output logic [HASH_W-1:0]   dataOut,
    input  logic                table_clear,
    output logic [DEPTH-1:0]    entry_valid,
    md5_target_table_if.slave   bus
);

    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    logic              commit_en;
    logic [IDX_W-1:0]  commit_idx;
    logic [HASH_W-1:0] commit_data;

    logic [HASH_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [HASH_W-1:0] rd_q,    rd_d;
    logic              sel_in_range;

    scan_state_t       sst_q,   sst_d;
    logic [IDX_W:0]    ptr_q,   ptr_d;
    logic              sv_q,    sv_d;
    logic [HASH_W-1:0] sdata_q, sdata_d;
    logic [IDX_W-1:0]  sidx_q,  sidx_d;
    logic              sdone_q, sdone_d;
    logic [IDX_W-1:0]  ptr_lo;
    logic              ptr_in_range;
    logic              slot_free;

    md5_byte_loader #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_loader (
        .CLK           (CLK),
        .reset         (reset),
        .load_start_i  (bus.load_start),
        .load_idx_i    (bus.load_idx),
        .in_data_i     (bus.in_data),
        .in_valid_i    (bus.in_valid),
        .in_ready_o    (bus.in_ready),
        .load_done_o   (bus.load_done),
        .load_err_o    (bus.load_err),
        .commit_en_o   (commit_en),
        .commit_idx_o  (commit_idx),
        .commit_data_o (commit_data)
    );

    // Digest storage is deliberately not reset; valid_q gates every read.
    always_ff @(posedge CLK) begin
        if (commit_en) begin
            mem_q[commit_idx] <= commit_data;
        end
    end

    // Clear first, then the commit, so a coincident commit survives.
    always_comb begin
        valid_d = valid_q;
        if (table_clear) begin
            valid_d = '0;
        end
        if (commit_en) begin
            valid_d[commit_idx] = 1'b1;
        end
    end

    assign sel_in_range = ({1'b0, selector} < DEPTH_C);

    always_comb begin
        rd_d = DEFAULT_HASH;
        if (sel_in_range && valid_q[selector]) begin
            rd_d = mem_q[selector];
        end
    end

    assign ptr_lo       = ptr_q[IDX_W-1:0];
    assign ptr_in_range = (ptr_q < DEPTH_C);
    assign slot_free    = !sv_q || bus.scan_ready;

    always_comb begin
        sst_d   = sst_q;
        ptr_d   = ptr_q;
        sv_d    = sv_q;
        sdata_d = sdata_q;
        sidx_d  = sidx_q;
        sdone_d = 1'b0;
        case (sst_q)
            SC_IDLE: begin
                if (bus.scan_start) begin
                    sst_d = SC_SCAN;
                    ptr_d = '0;
                end
            end
            SC_SCAN: begin
                if (slot_free) begin
                    if (ptr_in_range) begin
                        ptr_d = ptr_q + (IDX_W+1)'(1);
                        if (valid_q[ptr_lo]) begin
                            sv_d    = 1'b1;
                            sdata_d = mem_q[ptr_lo];
                            sidx_d  = ptr_lo;
                        end else begin
                            sv_d = 1'b0;
                        end
                    end else begin
                        // Last beat has drained; the sweep is over.
                        sv_d    = 1'b0;
                        sdone_d = 1'b1;
                        sst_d   = SC_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            valid_q <= '0;
            rd_q    <= '0;
            sst_q   <= SC_IDLE;
            ptr_q   <= '0;
            sv_q    <= 1'b0;
            sdata_q <= '0;
            sidx_q  <= '0;
            sdone_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            sst_q   <= sst_d;
            ptr_q   <= ptr_d;
            sv_q    <= sv_d;
            sdata_q <= sdata_d;
            sidx_q  <= sidx_d;
            sdone_q <= sdone_d;
        end
    end

    assign dataOut        = rd_q;
    assign entry_valid    = valid_q;
    assign bus.scan_valid = sv_q;
    assign bus.scan_data  = sdata_q;
    assign bus.scan_idx   = sidx_q;
    assign bus.scan_busy  = (sst_q == SC_SCAN);
    assign bus.scan_done  = sdone_q;

endmodule
